shift_arbiter: RTL and testbench

- Shares one logical shift datapath (left/right, zero-fill, amount 0-3) between two requesters.
- Each requester uses a valid/ready request handshake; results return on a single tagged response channel with its own valid/ready handshake.
- Sits between producer blocks and the team's shifter datapath.
- Serialises access, arbitrates fairly with round-robin, and registers operands and results so the shifter sees stable inputs for a full cycle.

---
 rtl/shift_arbiter.sv | 131 +++++++++++++
 tb/tb_shift_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - two-requester round-robin front end for a shared logical shifter
//
// Purpose:
//   Serialises shift operations from two requesters onto one shift datapath.
//   Each accepted request is registered (IDLE), shifted from the registered
//   operands (SHIFT), then returned on a tagged response channel (RESP).
//   Round-robin priority moves past the requester that just completed.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req0_valid/ready            requester 0 handshake
//   req0_data/amt/dir           requester 0 operand, shift amount, direction (0=left, 1=right)
//   req1_*                      same as requester 0, for requester 1
//   rsp_valid/ready             response handshake
//   rsp_id                      requester that owns the response
//   rsp_data                    shifted result
module shift_arbiter #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_data,
  input  logic [AMT_W-1:0] req0_amt,
  input  logic             req0_dir,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_data,
  input  logic [AMT_W-1:0] req1_amt,
  input  logic             req1_dir,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic             rr_ptr;
  logic [WIDTH-1:0] op_data;
  logic [AMT_W-1:0] op_amt;
  logic             op_dir;
  logic             op_id;

  logic             grant0;
  logic             grant1;
  logic             accept;
  logic             rsp_done;
  logic [WIDTH-1:0] shifted;

  // Contention is settled by rr_ptr; a lone requester always wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      grant0 = ~rr_ptr;
      grant1 = rr_ptr;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  // Readies are forced low while reset is asserted so nothing looks accepted.
  assign req0_ready = rst_n && (state == IDLE) && grant0;
  assign req1_ready = rst_n && (state == IDLE) && grant1;
  assign accept     = req0_ready || req1_ready;
  assign rsp_done   = (state == RESP) && rsp_valid && rsp_ready;

  // Amounts at or beyond WIDTH flush every bit out.
  always_comb begin
    shifted = '0;
    if (int'(op_amt) < WIDTH) begin
      if (op_dir) shifted = op_data >> op_amt;
      else        shifted = op_data << op_amt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)   state_nxt = SHIFT;
      SHIFT:                 state_nxt = RESP;
      RESP:    if (rsp_done) state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= 1'b0;
      op_data   <= '0;
      op_amt    <= '0;
      op_dir    <= 1'b0;
      op_id     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
    end else begin
      if (accept) begin
        op_data <= req1_ready ? req1_data : req0_data;
        op_amt  <= req1_ready ? req1_amt  : req0_amt;
        op_dir  <= req1_ready ? req1_dir  : req0_dir;
        op_id   <= req1_ready;
      end
      if (state == SHIFT) begin
        rsp_data  <= shifted;
        rsp_id    <= op_id;
        rsp_valid <= 1'b1;
      end
      if (rsp_done) begin
        rsp_valid <= 1'b0;
        rr_ptr    <= ~rsp_id;
      end
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// tb/tb_shift_arbiter.sv - directed table-driven bench for shift_arbiter
module tb_shift_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req0_ready, req0_dir;
  logic [3:0] req0_data;
  logic [1:0] req0_amt;
  logic       req1_valid, req1_ready, req1_dir;
  logic [3:0] req1_data;
  logic [1:0] req1_amt;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [3:0] rsp_data;

  int checks;
  int failures;

  shift_arbiter #(.WIDTH(4), .AMT_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_amt   (req0_amt),
    .req0_dir   (req0_dir),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_amt   (req1_amt),
    .req1_dir   (req1_dir),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       id;
    logic [3:0] data;
    logic [1:0] amt;
    logic       dir;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // One operation from a single requester with rsp_ready high: grant in the
  // current cycle, SHIFT next, RESP after that, back in IDLE the cycle after.
  task automatic run_op(input logic id, input logic [3:0] data, input logic [1:0] amt,
                        input logic dir, input logic [3:0] exp);
    rsp_ready = 1'b1;
    if (id) begin
      req1_data = data; req1_amt = amt; req1_dir = dir; req1_valid = 1'b1;
    end else begin
      req0_data = data; req0_amt = amt; req0_dir = dir; req0_valid = 1'b1;
    end
    #1;
    chk("op_grant_ready", id ? req1_ready : req0_ready, 1);
    chk("op_other_ready", id ? req0_ready : req1_ready, 0);
    step();
    chk("op_shift_readies", {req0_ready, req1_ready}, 0);
    chk("op_shift_rsp_valid", rsp_valid, 0);
    step();
    chk("op_rsp_valid", rsp_valid, 1);
    chk("op_rsp_id", rsp_id, id);
    chk("op_rsp_data", rsp_data, exp);
    chk("op_resp_readies", {req0_ready, req1_ready}, 0);
    step();
    chk("op_done_rsp_valid", rsp_valid, 0);
    if (id) req1_valid = 1'b0;
    else    req0_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;

    vecs[0] = '{1'b0, 4'b1101, 2'd1, 1'b0, 4'b1010};
    vecs[1] = '{1'b1, 4'b1101, 2'd2, 1'b1, 4'b0011};
    vecs[2] = '{1'b1, 4'b1101, 2'd0, 1'b1, 4'b1101};
    vecs[3] = '{1'b1, 4'b1101, 2'd3, 1'b0, 4'b1000};
    vecs[4] = '{1'b0, 4'b0110, 2'd1, 1'b1, 4'b0011};
    vecs[5] = '{1'b1, 4'b1111, 2'd3, 1'b1, 4'b0001};
    vecs[6] = '{1'b0, 4'b1001, 2'd2, 1'b0, 4'b0100};
    vecs[7] = '{1'b1, 4'b0001, 2'd0, 1'b0, 4'b0001};

    rst_n = 1'b0;
    req0_valid = 1'b0; req0_data = '0; req0_amt = '0; req0_dir = 1'b0;
    req1_valid = 1'b0; req1_data = '0; req1_amt = '0; req1_dir = 1'b0;
    rsp_ready = 1'b0;

    // Reset state
    step();
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_id", rsp_id, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_readies", {req0_ready, req1_ready}, 0);
    step();
    rst_n = 1'b1;

    // Shift arithmetic and single-requester handshakes
    for (int i = 0; i < 8; i++)
      run_op(vecs[i].id, vecs[i].data, vecs[i].amt, vecs[i].dir, vecs[i].exp);

    // Both requesters held: grants and responses alternate 0,1,0,1
    do_reset();
    req0_data = 4'b0001; req0_amt = 2'd1; req0_dir = 1'b0;
    req1_data = 4'b1000; req1_amt = 2'd1; req1_dir = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_req0_ready", req0_ready, (i % 2 == 0) ? 1 : 0);
      chk("rr_req1_ready", req1_ready, (i % 2 == 1) ? 1 : 0);
      step();
      step();
      chk("rr_rsp_valid", rsp_valid, 1);
      chk("rr_rsp_id", rsp_id, i % 2);
      chk("rr_rsp_data", rsp_data, (i % 2 == 1) ? 4'b0100 : 4'b0010);
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();

    // Response back-pressure: outputs hold, nothing else accepted
    req0_data = 4'b0011; req0_amt = 2'd2; req0_dir = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b0;
    #1;
    chk("bp_grant0", req0_ready, 1);
    step();
    step();
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold_valid", rsp_valid, 1);
      chk("bp_hold_id", rsp_id, 0);
      chk("bp_hold_data", rsp_data, 4'b1100);
      chk("bp_hold_readies", {req0_ready, req1_ready}, 0);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_valid_before_edge", rsp_valid, 1);
    step();
    chk("bp_done_valid", rsp_valid, 0);
    chk("bp_next_req1_ready", req1_ready, 1);
    chk("bp_next_req0_ready", req0_ready, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();

    // Reset while in RESP, then round-robin pointer back at requester 0
    rsp_ready = 1'b0;
    req1_data = 4'b1111; req1_amt = 2'd0; req1_dir = 1'b0; req1_valid = 1'b1;
    #1;
    chk("rst_req1_grant", req1_ready, 1);
    step();
    step();
    chk("rst_pre_rsp_valid", rsp_valid, 1);
    chk("rst_pre_rsp_data", rsp_data, 4'b1111);
    req0_data = 4'b0101; req0_amt = 2'd1; req0_dir = 1'b1; req0_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", rsp_valid, 0);
    chk("rst_async_data", rsp_data, 0);
    chk("rst_async_id", rsp_id, 0);
    chk("rst_readies", {req0_ready, req1_ready}, 0);
    step();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    #1;
    chk("rst_post_req0_ready", req0_ready, 1);
    chk("rst_post_req1_ready", req1_ready, 0);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    chk("rst_post_rsp_valid", rsp_valid, 1);
    chk("rst_post_rsp_id", rsp_id, 0);
    chk("rst_post_rsp_data", rsp_data, 4'b0010);
    step();
    chk("rst_post_done", rsp_valid, 0);

    // Persistent single requester served back-to-back every 3 cycles
    run_op(1'b0, 4'b0011, 2'd1, 1'b0, 4'b0110);
    run_op(1'b0, 4'b1010, 2'd1, 1'b1, 4'b0101);
    run_op(1'b0, 4'b1111, 2'd2, 1'b0, 4'b1100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
